video_native_tx: RTL and testbench

VIDEO_NATIVE_TX -- requirements
Module: video_native_tx

---
 rtl/video_native_pkg.sv | 24 ++
 rtl/video_native_inf.sv | 15 +
 rtl/video_timing_gen.sv | 57 +++++
 rtl/video_native_tx.sv | 165 ++++++++++++++++
 tb/tb_video_native_tx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/video_native_pkg.sv
// Shared types for the native video transmitter: controller states and the
// per-axis timing record used to parameterise the timing generator.
package video_native_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEEK  = 3'd1,
    ST_ARMED = 3'd2,
    ST_RUN   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } axis_timing_t;

  function automatic int total_of(input axis_timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

endpackage

// File: rtl/video_native_inf.sv
// Bundle for the registered native video outputs; the transmitter drives the
// compact_out side, a sink or checker attaches through compact_in.
interface video_native_inf #(
  parameter int DSIZE = 24
);
  logic             vsync;
  logic             hsync;
  logic             de;
  logic [DSIZE-1:0] data;
  logic             underflow;
  logic             frame_err;

  modport compact_out (output vsync, hsync, de, data, underflow, frame_err);
  modport compact_in  (input  vsync, hsync, de, data, underflow, frame_err);
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster counters with region flags. Counters advance only while
// i_run is high and sit at (0,0) otherwise, so every run starts at line start.
module video_timing_gen import video_native_pkg::*; #(
  parameter axis_timing_t H_TIM = '{active: 16'd1920, fp: 16'd88, sync: 16'd44, bp: 16'd148},
  parameter axis_timing_t V_TIM = '{active: 16'd1080, fp: 16'd4,  sync: 16'd5,  bp: 16'd36}
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_h_sync,
  output logic o_v_sync,
  output logic o_h_act,
  output logic o_v_act,
  output logic o_first_act
);

  localparam int H_TOTAL = total_of(H_TIM);
  localparam int V_TOTAL = total_of(V_TIM);
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(int'(H_TIM.sync));
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(int'(H_TIM.sync) + int'(H_TIM.bp));
  localparam logic [HW-1:0] H_ACT_LAST = HW'(int'(H_TIM.sync) + int'(H_TIM.bp) + int'(H_TIM.active) - 1);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(int'(V_TIM.sync));
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(int'(V_TIM.sync) + int'(V_TIM.bp));
  localparam logic [VW-1:0] V_ACT_LAST = VW'(int'(V_TIM.sync) + int'(V_TIM.bp) + int'(V_TIM.active) - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!i_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
    end
  end

  // Line and frame both run sync, back porch, active, front porch.
  assign o_h_sync    = (r_hcnt < H_SYNC_END);
  assign o_v_sync    = (r_vcnt < V_SYNC_END);
  assign o_h_act     = (r_hcnt >= H_ACT_BEG) && (r_hcnt <= H_ACT_LAST);
  assign o_v_act     = (r_vcnt >= V_ACT_BEG) && (r_vcnt <= V_ACT_LAST);
  assign o_first_act = (r_hcnt == H_ACT_BEG) && (r_vcnt == V_ACT_BEG);

endmodule

// File: rtl/video_native_tx.sv
// Pixel stream to native video (hsync/vsync/de/data) transmitter. Locks the
// stream to the raster on start-of-frame and flags underflow and misalignment.
module video_native_tx import video_native_pkg::*; #(
  parameter int DSIZE    = 24,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_sof,
  output logic             vsync,
  output logic             hsync,
  output logic             de,
  output logic [DSIZE-1:0] data,
  output logic             underflow,
  output logic             frame_err,
  output state_t           dbg_state
);

  localparam axis_timing_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                     sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam axis_timing_t V_TIM = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                     sync: 16'(V_SYNC), bp: 16'(V_BP)};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_run;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_first;
  logic             w_act;
  logic             w_sof_ok;
  logic             w_ready;
  logic             w_take;
  logic             w_de;
  logic             w_uf;
  logic             w_fe;
  logic             r_vsync;
  logic             r_hsync;
  logic             r_de;
  logic [DSIZE-1:0] r_data;
  logic             r_uf;
  logic             r_fe;

  assign w_run = enable && (r_state != ST_IDLE);

  video_timing_gen #(
    .H_TIM (H_TIM),
    .V_TIM (V_TIM)
  ) u_timing (
    .i_clk       (pclk),
    .i_rst       (prst),
    .i_run       (w_run),
    .o_h_sync    (w_h_sync),
    .o_v_sync    (w_v_sync),
    .o_h_act     (w_h_act),
    .o_v_act     (w_v_act),
    .o_first_act (w_first)
  );

  assign w_act    = w_h_act && w_v_act;
  assign w_sof_ok = s_valid && s_sof;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A beat transfers on a rising edge where s_valid and s_ready are both high.
  // s_ready may depend on s_valid/s_sof in the same cycle (a beat that would
  // misalign the frame is refused) but s_valid never waits on s_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_take      = 1'b0;
    w_de        = 1'b0;
    w_uf        = 1'b0;
    w_fe        = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_SEEK;
        ST_SEEK: begin
          if (w_sof_ok) w_state_nxt = ST_ARMED;
          else          w_ready     = 1'b1;
        end
        ST_ARMED, ST_HOLD: begin
          // Both wait for the frame's first active slot to take the held SOF beat.
          if (w_act && w_first) begin
            w_de = 1'b1;
            if (w_sof_ok) begin
              w_ready     = 1'b1;
              w_take      = 1'b1;
              w_state_nxt = ST_RUN;
            end else begin
              w_fe        = 1'b1;
              w_state_nxt = ST_SEEK;
            end
          end else if (w_act && (r_state == ST_HOLD)) begin
            w_de = 1'b1;
          end
        end
        ST_RUN: begin
          if (w_act) begin
            w_de = 1'b1;
            if (!s_valid) begin
              w_ready = 1'b1;
              w_uf    = 1'b1;
            end else if (s_sof != w_first) begin
              w_fe        = 1'b1;
              w_state_nxt = w_first ? ST_SEEK : ST_HOLD;
            end else begin
              w_ready = 1'b1;
              w_take  = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_hsync <= !HS_POL;
      r_vsync <= !VS_POL;
      r_de    <= 1'b0;
      r_data  <= '0;
      r_uf    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_hsync <= (w_run && w_h_sync) ? HS_POL : !HS_POL;
      r_vsync <= (w_run && w_v_sync) ? VS_POL : !VS_POL;
      r_de    <= w_de;
      r_data  <= w_take ? s_data : '0;
      r_uf    <= w_uf;
      r_fe    <= w_fe;
    end
  end

  assign s_ready   = w_ready;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign de        = r_de;
  assign data      = r_data;
  assign underflow = r_uf;
  assign frame_err = r_fe;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_video_native_tx.sv
// Directed bench for video_native_tx on a 7x5 raster (H 4/1/1/1, V 2/1/1/1):
// table of stream scenarios plus hand sequences for sync timing, reset and enable.
module tb_video_native_tx;
  import video_native_pkg::*;

  localparam int DSIZE = 24;
  localparam int SOF   = 32'h0100_0000;
  localparam int WIN   = 70;
  localparam int NVEC  = 5;

  typedef struct {
    int n_beats;
    int beats [20];
    int exp_de;
    int exp_data [16];
    int exp_uf;
    int exp_fe;
  } vec_t;

  logic             pclk = 1'b0;
  logic             prst = 1'b1;
  logic             enable = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DSIZE-1:0] s_data = '0;
  logic             s_sof = 1'b0;
  logic             vsync, hsync, de, underflow, frame_err;
  logic [DSIZE-1:0] data;
  state_t           dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DSIZE-1:0] exp_q[$];
  vec_t vecs [NVEC];

  video_native_tx #(
    .DSIZE(DSIZE), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pclk(pclk), .prst(prst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .vsync(vsync), .hsync(hsync), .de(de), .data(data),
    .underflow(underflow), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " de"}, 32'(de), 0);
    check({tag, " data"}, 32'(data), 0);
    check({tag, " hsync"}, 32'(hsync), 0);
    check({tag, " vsync"}, 32'(vsync), 0);
    check({tag, " s_ready"}, 32'(s_ready), 0);
    check({tag, " underflow"}, 32'(underflow), 0);
    check({tag, " frame_err"}, 32'(frame_err), 0);
    check({tag, " state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic do_reset();
    prst = 1'b1;
    enable = 1'b0;
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_data = '0;
    repeat (2) @(negedge pclk);
    prst = 1'b0;
  endtask

  // Enables from IDLE with no stream; hsync/vsync follow the raster one cycle late.
  task automatic timing_scan(input int n, input string tag);
    logic exp_hs, exp_vs;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      exp_hs = (i >= 2) && (((i - 2) % 7) == 0);
      exp_vs = (i >= 2) && (((i - 2) % 35) < 7);
      check($sformatf("%s hsync c%0d", tag, i), 32'(hsync), 32'(exp_hs));
      check($sformatf("%s vsync c%0d", tag, i), 32'(vsync), 32'(exp_vs));
      check($sformatf("%s de c%0d", tag, i), 32'(de), 0);
      enable = 1'b1;
    end
    check({tag, " state"}, 32'(dbg_state), 32'(ST_SEEK));
  endtask

  // driver + scoreboard for one table record; abort_at >= 0 asserts prst mid-run
  task automatic run_vec(input int idx, input int abort_at);
    int k, de_seen, uf_cnt, fe_cnt, b;
    logic aborted;
    logic [DSIZE-1:0] exp_d;
    k = 0; de_seen = 0; uf_cnt = 0; fe_cnt = 0; aborted = 1'b0;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < vecs[idx].exp_de; i++) exp_q.push_back(DSIZE'(vecs[idx].exp_data[i]));
    for (int i = 0; i < WIN && !aborted; i++) begin
      @(negedge pclk);
      if (i == abort_at) begin
        check($sformatf("v%0d de before abort", idx), 32'(de), 1);
        prst = 1'b1;
        #1;
        check_reset_outputs($sformatf("v%0d async reset", idx));
        aborted = 1'b1;
      end else begin
        if (de) begin
          if (exp_q.size() == 0) begin
            check($sformatf("v%0d extra de c%0d", idx, i), 32'(de), 0);
          end else begin
            exp_d = exp_q.pop_front();
            check($sformatf("v%0d data[%0d]", idx, de_seen), 32'(data), 32'(exp_d));
          end
          de_seen++;
        end else begin
          check($sformatf("v%0d idle data c%0d", idx, i), 32'(data), 0);
        end
        if (underflow) uf_cnt++;
        if (frame_err) fe_cnt++;
        enable = 1'b1;
        b = (k < vecs[idx].n_beats) ? vecs[idx].beats[k] : 0;
        s_valid = (b != 0);
        s_sof = ((b & SOF) != 0);
        s_data = DSIZE'(b & 32'h00FF_FFFF);
        #1;
        if (s_ready && (k < vecs[idx].n_beats)) k++;
      end
    end
    if (!aborted) begin
      check($sformatf("v%0d de count", idx), 32'(de_seen), 32'(vecs[idx].exp_de));
      check($sformatf("v%0d underflow count", idx), 32'(uf_cnt), 32'(vecs[idx].exp_uf));
      check($sformatf("v%0d frame_err count", idx), 32'(fe_cnt), 32'(vecs[idx].exp_fe));
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  initial begin
    // v0: clean stream 1..16, SOF on 1 and 9
    vecs[0].n_beats = 16; vecs[0].exp_de = 16;
    for (int p = 0; p < 16; p++) begin
      vecs[0].beats[p] = (p + 1) | (((p % 8) == 0) ? SOF : 0);
      vecs[0].exp_data[p] = p + 1;
    end
    // v1: valid dropped for pixel 3 in frame 0
    vecs[1].n_beats = 17; vecs[1].exp_de = 16; vecs[1].exp_uf = 1;
    for (int p = 0; p < 17; p++) begin
      if (p == 0)      vecs[1].beats[p] = SOF | 1;
      else if (p == 1) vecs[1].beats[p] = 2;
      else if (p == 2) vecs[1].beats[p] = 0;
      else if (p < 8)  vecs[1].beats[p] = p;
      else if (p == 8) vecs[1].beats[p] = SOF | 9;
      else             vecs[1].beats[p] = p + 1;
    end
    for (int p = 0; p < 16; p++)
      vecs[1].exp_data[p] = (p < 2) ? p + 1 : (p == 2) ? 0 : (p < 8) ? p : p + 1;
    // v2: early SOF on pixel 5, frame resumes with it next frame
    vecs[2].n_beats = 12; vecs[2].exp_de = 16; vecs[2].exp_fe = 1;
    for (int p = 0; p < 12; p++)
      vecs[2].beats[p] = (p + 1) | ((p == 0 || p == 4) ? SOF : 0);
    for (int p = 0; p < 16; p++)
      vecs[2].exp_data[p] = (p < 4) ? p + 1 : (p < 8) ? 0 : p - 3;
    // v3: non-SOF beats discarded while seeking, stream then runs dry
    vecs[3].n_beats = 10; vecs[3].exp_de = 16; vecs[3].exp_uf = 8;
    vecs[3].beats[0] = 32'hA; vecs[3].beats[1] = 32'hB;
    for (int p = 2; p < 10; p++) vecs[3].beats[p] = (p - 1) | ((p == 2) ? SOF : 0);
    for (int p = 0; p < 16; p++) vecs[3].exp_data[p] = (p < 8) ? p + 1 : 0;
    // v4: frame 1 starts without SOF -> error, back to seeking
    vecs[4].n_beats = 9; vecs[4].exp_de = 9; vecs[4].exp_fe = 1;
    for (int p = 0; p < 8; p++) vecs[4].beats[p] = (p + 1) | ((p == 0) ? SOF : 0);
    vecs[4].beats[8] = 32'h20;
    for (int p = 0; p < 9; p++) vecs[4].exp_data[p] = (p < 8) ? p + 1 : 0;

    // reset values, then raster timing with no stream
    repeat (2) @(negedge pclk);
    check_reset_outputs("reset");
    do_reset();
    timing_scan(40, "scan");

    // enable drop: ready falls at once, outputs go inactive next cycle
    @(negedge pclk);
    enable = 1'b0;
    #1;
    check("enable-off s_ready", 32'(s_ready), 0);
    @(negedge pclk);
    check("enable-off state", 32'(dbg_state), 32'(ST_IDLE));
    check("enable-off hsync", 32'(hsync), 0);
    check("enable-off vsync", 32'(vsync), 0);
    check("enable-off de", 32'(de), 0);
    timing_scan(16, "rescan");

    for (int v = 0; v < NVEC; v++) run_vec(v, -1);

    // reset in the middle of an active line, then a clean re-sync
    run_vec(0, 20);
    run_vec(0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
